// File: rtl/status_led_ctrl.sv
// Status LED arbiter: fault-code blinker > activity flasher > heartbeat,
// all timed in prescaled ticks and sequenced by one FSM driving a registered LED.
module status_led_ctrl #(
    parameter int TICK_DIV  = 500000,
    parameter int HB_HALF   = 50,
    parameter int ACT_TICKS = 5,
    parameter int CODE_ON   = 20,
    parameter int CODE_OFF  = 20,
    parameter int CODE_GAP  = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] fault_code,
    input  logic       act_pulse,
    output logic       led,
    output logic       code_active,
    output logic       tick
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int M1   = (HB_HALF > ACT_TICKS) ? HB_HALF : ACT_TICKS;
    localparam int M2   = (CODE_ON > CODE_OFF) ? CODE_ON : CODE_OFF;
    localparam int M3   = (M1 > M2) ? M1 : M2;
    localparam int TMAX = (M3 > CODE_GAP) ? M3 : CODE_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] HB_LAST    = TW'(HB_HALF - 1);
    localparam logic [TW-1:0] ACT_LAST   = TW'(ACT_TICKS - 1);
    localparam logic [TW-1:0] ON_LAST    = TW'(CODE_ON - 1);
    localparam logic [TW-1:0] OFF_LAST   = TW'(CODE_OFF - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(CODE_GAP - 1);

    typedef enum logic [2:0] {
        ST_HB,
        ST_ACT_ON,
        ST_ACT_OFF,
        ST_CODE_ON,
        ST_CODE_OFF,
        ST_CODE_GAP
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc;
    logic [TW-1:0] hb_cnt, hb_cnt_n;
    logic          hb_phase, hb_phase_n;
    logic [TW-1:0] tcnt, tcnt_n, lim;
    logic [3:0]    blink_cnt, blink_n;
    logic [3:0]    code_lat, code_n;
    logic          act_pend, pend_n;
    logic          led_n, ca_n, done, start_code;

    assign tick = (presc == PRESC_LAST);

    // Free-running prescaler, independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_HB;
            hb_cnt      <= '0;
            hb_phase    <= 1'b0;
            tcnt        <= '0;
            blink_cnt   <= '0;
            code_lat    <= '0;
            act_pend    <= 1'b0;
            led         <= 1'b0;
            code_active <= 1'b0;
        end else begin
            state       <= state_n;
            hb_cnt      <= hb_cnt_n;
            hb_phase    <= hb_phase_n;
            tcnt        <= tcnt_n;
            blink_cnt   <= blink_n;
            code_lat    <= code_n;
            act_pend    <= pend_n;
            led         <= led_n;
            code_active <= ca_n;
        end
    end

    always_comb begin
        state_n    = state;
        hb_cnt_n   = hb_cnt;
        hb_phase_n = hb_phase;
        tcnt_n     = tcnt;
        blink_n    = blink_cnt;
        code_n     = code_lat;
        pend_n     = act_pend;
        start_code = 1'b0;
        lim        = '0;
        led_n      = 1'b0;
        ca_n       = 1'b0;

        if (tick) begin
            if (hb_cnt == HB_LAST) begin
                hb_cnt_n   = '0;
                hb_phase_n = ~hb_phase;
            end else begin
                hb_cnt_n = hb_cnt + TW'(1);
            end
        end

        case (state)
            ST_ACT_ON, ST_ACT_OFF: lim = ACT_LAST;
            ST_CODE_ON:            lim = ON_LAST;
            ST_CODE_OFF:           lim = OFF_LAST;
            ST_CODE_GAP:           lim = GAP_LAST;
            default:               lim = '0;
        endcase

        // The entry cycle always clears tcnt below, so a coincident tick is not counted.
        done = tick && (tcnt == lim);
        if (tick && !done && state != ST_HB) begin
            tcnt_n = tcnt + TW'(1);
        end

        case (state)
            ST_HB: begin
                if (fault_code != 4'd0) begin
                    start_code = 1'b1;
                end else if (act_pulse || act_pend) begin
                    state_n = ST_ACT_ON;
                    pend_n  = 1'b0;
                    tcnt_n  = '0;
                end
            end
            ST_ACT_ON: begin
                if (fault_code != 4'd0) begin
                    start_code = 1'b1;
                end else begin
                    if (act_pulse) pend_n = 1'b1;
                    if (done) begin
                        state_n = ST_ACT_OFF;
                        tcnt_n  = '0;
                    end
                end
            end
            ST_ACT_OFF: begin
                if (fault_code != 4'd0) begin
                    start_code = 1'b1;
                end else if (done) begin
                    tcnt_n = '0;
                    pend_n = 1'b0;
                    state_n = (act_pend || act_pulse) ? ST_ACT_ON : ST_HB;
                end else if (act_pulse) begin
                    pend_n = 1'b1;
                end
            end
            ST_CODE_ON: begin
                if (done) begin
                    blink_n = blink_cnt + 4'd1;
                    tcnt_n  = '0;
                    state_n = (blink_n == code_lat) ? ST_CODE_GAP : ST_CODE_OFF;
                end
            end
            ST_CODE_OFF: begin
                if (done) begin
                    state_n = ST_CODE_ON;
                    tcnt_n  = '0;
                end
            end
            ST_CODE_GAP: begin
                if (done) begin
                    tcnt_n = '0;
                    if (fault_code != 4'd0) start_code = 1'b1;
                    else                    state_n = ST_HB;
                end
            end
            default: state_n = ST_HB;
        endcase

        if (start_code) begin
            state_n = ST_CODE_ON;
            code_n  = fault_code;
            blink_n = '0;
            tcnt_n  = '0;
            pend_n  = 1'b0;
        end

        // Outputs decode the next state so they register together with it.
        case (state_n)
            ST_HB:                  led_n = hb_phase_n;
            ST_ACT_ON, ST_CODE_ON:  led_n = 1'b1;
            default:                led_n = 1'b0;
        endcase
        ca_n = (state_n == ST_CODE_ON) || (state_n == ST_CODE_OFF) ||
               (state_n == ST_CODE_GAP);
    end

endmodule

// File: tb/tb_status_led_ctrl.sv
// Directed bench for status_led_ctrl with small timing parameters; every scenario
// runs on one continuous timeline so heartbeat phase is known from the edge count.
module tb_status_led_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] fault_code = 4'd0;
  logic       act_pulse = 1'b0;
  logic       led, code_active, tick;

  int n_cmp = 0;
  int n_err = 0;
  int ecnt = 0;

  status_led_ctrl #(
    .TICK_DIV(4), .HB_HALF(3), .ACT_TICKS(2),
    .CODE_ON(2), .CODE_OFF(2), .CODE_GAP(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fault_code(fault_code),
    .act_pulse(act_pulse),
    .led(led),
    .code_active(code_active),
    .tick(tick)
  );

  always #5 clk = ~clk;

  // Ticks land on edges 4,8,12..; phase flips every third tick, i.e. every 12 edges.
  function automatic logic hb_exp(int e);
    return ((e / 12) % 2) == 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL reset_led got=%b want=0", led); end
    n_cmp++; if (code_active !== 1'b0) begin n_err++; $display("FAIL reset_ca got=%b want=0", code_active); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b want=0", tick); end
    @(negedge clk);
    rst_n = 1'b1;
    ecnt = 0;
  endtask

  task automatic test_heartbeat();
    logic exp_tick;
    for (int k = 0; k < 40; k++) begin
      step();
      exp_tick = ((ecnt % 4) == 3);
      n_cmp++; if (tick !== exp_tick) begin n_err++; $display("FAIL hb_tick e=%0d got=%b want=%b", ecnt, tick, exp_tick); end
      n_cmp++; if (led !== hb_exp(ecnt)) begin n_err++; $display("FAIL hb_led e=%0d got=%b want=%b", ecnt, led, hb_exp(ecnt)); end
      n_cmp++; if (code_active !== 1'b0) begin n_err++; $display("FAIL hb_ca e=%0d got=%b want=0", ecnt, code_active); end
    end
  endtask

  task automatic test_fault_code3();
    int seg_val[13] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 2};
    int seg_len[13] = '{7, 8, 8, 8, 8, 20, 8, 8, 8, 8, 8, 20, 4};
    int seg_ca[13]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic exp_led, exp_ca;
    fault_code = 4'd3;
    for (int s = 0; s < 13; s++) begin
      for (int k = 0; k < seg_len[s]; k++) begin
        step();
        exp_led = (seg_val[s] == 2) ? hb_exp(ecnt) : (seg_val[s] == 1);
        exp_ca = (seg_ca[s] == 1);
        n_cmp++; if (led !== exp_led) begin n_err++; $display("FAIL code3_led e=%0d got=%b want=%b", ecnt, led, exp_led); end
        n_cmp++; if (code_active !== exp_ca) begin n_err++; $display("FAIL code3_ca e=%0d got=%b want=%b", ecnt, code_active, exp_ca); end
        if (ecnt == 101) fault_code = 4'd0;
      end
    end
  endtask

  task automatic test_activity();
    int seg_val[8] = '{1, 0, 2, 1, 0, 1, 0, 2};
    int seg_len[8] = '{8, 8, 15, 5, 8, 8, 8, 8};
    logic exp_led;
    act_pulse = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < seg_len[s]; k++) begin
        step();
        exp_led = (seg_val[s] == 2) ? hb_exp(ecnt) : (seg_val[s] == 1);
        n_cmp++; if (led !== exp_led) begin n_err++; $display("FAIL act_led e=%0d got=%b want=%b", ecnt, led, exp_led); end
        n_cmp++; if (code_active !== 1'b0) begin n_err++; $display("FAIL act_ca e=%0d got=%b want=0", ecnt, code_active); end
        act_pulse = (ecnt == 194) || (ecnt == 196) || (ecnt == 198);
      end
    end
  endtask

  task automatic test_fault_preempt();
    int seg_val[7] = '{2, 1, 1, 0, 1, 0, 2};
    int seg_len[7] = '{5, 4, 7, 8, 8, 20, 16};
    int seg_ca[7]  = '{0, 0, 1, 1, 1, 1, 0};
    logic exp_led, exp_ca;
    for (int s = 0; s < 7; s++) begin
      for (int k = 0; k < seg_len[s]; k++) begin
        step();
        exp_led = (seg_val[s] == 2) ? hb_exp(ecnt) : (seg_val[s] == 1);
        exp_ca = (seg_ca[s] == 1);
        n_cmp++; if (led !== exp_led) begin n_err++; $display("FAIL preempt_led e=%0d got=%b want=%b", ecnt, led, exp_led); end
        n_cmp++; if (code_active !== exp_ca) begin n_err++; $display("FAIL preempt_ca e=%0d got=%b want=%b", ecnt, code_active, exp_ca); end
        act_pulse = (ecnt == 236) || (ecnt == 238);
        fault_code = (ecnt == 240) ? 4'd2 : 4'd0;
      end
    end
  endtask

  task automatic test_code_change();
    int seg_val[17] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 2};
    int seg_len[17] = '{8, 8, 8, 8, 8, 20, 8, 8, 8, 8, 8, 8, 8, 8, 8, 20, 8};
    logic exp_led, exp_ca;
    fault_code = 4'd3;
    for (int s = 0; s < 17; s++) begin
      for (int k = 0; k < seg_len[s]; k++) begin
        step();
        exp_led = (seg_val[s] == 2) ? hb_exp(ecnt) : (seg_val[s] == 1);
        exp_ca = (s < 16);
        n_cmp++; if (led !== exp_led) begin n_err++; $display("FAIL change_led e=%0d got=%b want=%b", ecnt, led, exp_led); end
        n_cmp++; if (code_active !== exp_ca) begin n_err++; $display("FAIL change_ca e=%0d got=%b want=%b", ecnt, code_active, exp_ca); end
        if (ecnt == 318) fault_code = 4'd5;
        if (ecnt == 380) fault_code = 4'd0;
      end
    end
  endtask

  task automatic test_async_reset();
    logic exp_tick;
    fault_code = 4'd1;
    step();
    n_cmp++; if (led !== 1'b1) begin n_err++; $display("FAIL arst_pre_led got=%b want=1", led); end
    n_cmp++; if (code_active !== 1'b1) begin n_err++; $display("FAIL arst_pre_ca got=%b want=1", code_active); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL arst_led got=%b want=0", led); end
    n_cmp++; if (code_active !== 1'b0) begin n_err++; $display("FAIL arst_ca got=%b want=0", code_active); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL arst_tick got=%b want=0", tick); end
    fault_code = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ecnt = 0;
    for (int k = 0; k < 28; k++) begin
      step();
      exp_tick = ((ecnt % 4) == 3);
      n_cmp++; if (tick !== exp_tick) begin n_err++; $display("FAIL arst_hb_tick e=%0d got=%b want=%b", ecnt, tick, exp_tick); end
      n_cmp++; if (led !== hb_exp(ecnt)) begin n_err++; $display("FAIL arst_hb_led e=%0d got=%b want=%b", ecnt, led, hb_exp(ecnt)); end
      n_cmp++; if (code_active !== 1'b0) begin n_err++; $display("FAIL arst_hb_ca e=%0d got=%b want=0", ecnt, code_active); end
    end
  endtask

  initial begin
    test_reset();
    test_heartbeat();
    test_fault_code3();
    test_activity();
    test_fault_preempt();
    test_code_change();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
